ip_head_pack: RTL and testbench
===============================

// Module: ip_head_pack
// PURPOSE
//  Builds the 20-byte IPv4 header of each outgoing UDP frame and writes it into the tx buffer RAM, ahead of the UDP stage.
//  Computes the header checksum before writing; header occupies RAM bytes 22..41 (after the 8B preamble/SFD and 14B Ethernet header).
//  Pulses ip_head_end when the header is complete, which starts the UDP packer. Sits between the Ethernet-header packer and the UDP packer.
// PARAMETERS
//  RAM_BASE   10'd22    RAM address of IP header byte 0
//  IP_TOT_LEN 16'd989   IPv4 total length (20 IP + 969 UDP)
//  IP_TTL     8'h40     time-to-live
//  ADDR_W     10        buffer RAM address width
// PORTS
//  clk            in   1       system clock; the block has one clock
//  rst            in   1       synchronous reset, active-high
//  src_ip         in   32      source IPv4 address; sampled at start
//  des_ip         in   32      destination IPv4 address; sampled at start
//  eth_head_end   in   1       1-cycle start pulse from the Ethernet-header stage
//  ip_head_end    out  1       1-cycle done pulse to the UDP stage
//  ip_busy        out  1       high from the start pulse being accepted until ip_head_end
//  ip_wram_clk_en out  1       RAM write strobe
//  ip_wram_addr   out  ADDR_W  RAM write address
//  ip_wram_dat    out  8       RAM write data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, id_cnt=0, checksum accumulator=0. Reset mid-frame aborts immediately; no partial done pulse.
//  - Header bytes, index 0..19: 45 00 | TOT_LEN[15:8] TOT_LEN[7:0] | id[15:8] id[7:0] | 40 00 (DF set) | TTL 11 | csum[15:8] csum[7:0] | src_ip MSB-first | des_ip MSB-first.
//  - FSM states and transitions:
//      IDLE  -> SUM on eth_head_end. src_ip and des_ip are latched on this edge; the accumulator is cleared.
//      SUM   10 cycles; word_cnt 0..9; adds header 16-bit word[word_cnt] into a 20-bit accumulator. Word 5 (the checksum field) is added as 0.
//      FOLD  2 cycles; each cycle acc <= acc[15:0] + acc[19:16]. csum = ~acc[15:0].
//      HEAD  20 cycles; byte_cnt 0..19.
//      DONE  1 cycle; id_cnt increments (16-bit, wraps FFFF->0000). Next state is IDLE.
//  - Write timing (all outputs registered). While in HEAD with byte_cnt=k, the next cycle drives:
//      ip_wram_clk_en=1, ip_wram_addr=RAM_BASE+k, ip_wram_dat=byte k.
//    Outside HEAD, clk_en=0 and addr/dat hold their values.
//  - Latency: eth_head_end at cycle T.
//      Writes are strobed at T+14..T+33.
//      ip_head_end=1 at T+34 only (registered from DONE).
//      ip_busy=1 from T+1 to T+34 inclusive.
//  - eth_head_end while not in IDLE is ignored, with no queueing. A pulse arriving in the same cycle ip_head_end is high is also ignored.
//  - Address arithmetic is ADDR_W bits, unsigned. RAM_BASE+19 must not exceed 2^ADDR_W-1; this is not checked in RTL.
//  - The checksum is recomputed for every frame, because id_cnt changes each frame.
// STRUCTURE
//  - tcpip_pkg holds shared constants:
//      IPV4_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, IP_FLAGS_DF=16'h4000
//      frame offsets: OFS_IP=22, OFS_UDP=42
//      state encodings: 3-bit, localparams
//  - One sub-module: ip_csum16. It is the 20-bit one's-complement accumulator with clear, add-word and fold controls, and outputs ~sum[15:0]. It is reusable later for the UDP checksum.
//  - The top level holds the FSM, counters, the header-word mux, the byte mux and the output registers.
// TESTING
//  1. Checksum: src=C0A80102, des=C0A80101, id=0, pulse eth_head_end -> bytes 10/11 = B3, BC; the full 20-byte image matches the golden model.
//  2. Timing: pulse at T -> exactly 20 strobes at T+14..T+33, addr 22..41 ascending, ip_head_end only at T+34, ip_busy T+1..T+34.
//  3. Id/wrap: run 3 frames -> id bytes 0000, 0001, 0002. Force id_cnt=FFFF, run 2 frames -> FFFF then 0000, checksum correct for each.
//  4. Ignored start: extra eth_head_end pulses at T+5 and T+34 -> still one frame of 20 writes and a single ip_head_end.
//  5. Reset mid-frame: assert rst at T+20 for 1 cycle -> clk_en=0 the next cycle, no ip_head_end, id_cnt=0. A new pulse then produces a correct full header.
//  6. Input change: change src_ip at T+5 -> the written header and checksum use the value latched at T.

Source files
------------

// File: rtl/tcpip_pkg.sv
// Constants shared by the UDP/IP transmit packers: header field values,
// frame byte offsets and the IP-header FSM state encodings.
package tcpip_pkg;

  localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;

  localparam int OFS_IP  = 22;
  localparam int OFS_UDP = 42;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SUM  = 3'd1;
  localparam logic [2:0] ST_FOLD = 3'd2;
  localparam logic [2:0] ST_HEAD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SUM  = ST_SUM,
    S_FOLD = ST_FOLD,
    S_HEAD = ST_HEAD,
    S_DONE = ST_DONE
  } ip_state_e;

endpackage

// File: rtl/ip_csum16.sv
// 20-bit one's-complement accumulator with clear / add-word / fold controls.
// The carry nibble absorbs up to 16 word additions before folding.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (add) begin
      acc_reg <= acc_reg + {4'b0, word};
    end else if (fold) begin
      acc_reg <= {4'b0, acc_reg[15:0]} + {16'b0, acc_reg[19:16]};
    end
  end

  assign csum = ~acc_reg[15:0];

endmodule

// File: rtl/ip_head_pack.sv
// Builds the 20-byte IPv4 header (checksum first, then byte writes) into the
// tx buffer RAM and pulses ip_head_end to start the UDP stage.
module ip_head_pack
  import tcpip_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] RAM_BASE   = ADDR_W'(OFS_IP),
  parameter logic [15:0]       IP_TOT_LEN = 16'd989,
  parameter logic [7:0]        IP_TTL     = 8'h40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       src_ip,
  input  logic [31:0]       des_ip,
  input  logic              eth_head_end,
  output logic              ip_head_end,
  output logic              ip_busy,
  output logic              ip_wram_clk_en,
  output logic [ADDR_W-1:0] ip_wram_addr,
  output logic [7:0]        ip_wram_dat
);

  ip_state_e         state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic [15:0]       id_cnt_reg, id_cnt_next;
  logic [31:0]       src_reg, des_reg;
  logic              wr_en_reg, head_end_reg, busy_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        dat_reg;

  logic              start;
  logic              csum_clr, csum_add, csum_fold;
  logic [15:0]       csum;
  logic [3:0]        word_idx;
  logic [15:0]       hdr_word;
  logic [7:0]        hdr_byte;

  // One counter serves as word index (SUM), fold count (FOLD) and byte index (HEAD).
  assign start    = (state_reg == S_IDLE) && eth_head_end && !head_end_reg;
  assign word_idx = (state_reg == S_HEAD) ? cnt_reg[4:1] : cnt_reg[3:0];

  always_comb begin
    hdr_word = 16'h0000;
    case (word_idx)
      4'd0:    hdr_word = {IPV4_VER_IHL, 8'h00};
      4'd1:    hdr_word = IP_TOT_LEN;
      4'd2:    hdr_word = id_cnt_reg;
      4'd3:    hdr_word = IP_FLAGS_DF;
      4'd4:    hdr_word = {IP_TTL, IP_PROTO_UDP};
      4'd5:    hdr_word = (state_reg == S_HEAD) ? csum : 16'h0000;
      4'd6:    hdr_word = src_reg[31:16];
      4'd7:    hdr_word = src_reg[15:0];
      4'd8:    hdr_word = des_reg[31:16];
      4'd9:    hdr_word = des_reg[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  assign hdr_byte = cnt_reg[0] ? hdr_word[7:0] : hdr_word[15:8];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 5'd1;
    id_cnt_next = id_cnt_reg;
    csum_clr    = 1'b0;
    csum_add    = 1'b0;
    csum_fold   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = 5'd0;
        if (start) begin
          state_next = S_SUM;
          csum_clr   = 1'b1;
        end
      end
      S_SUM: begin
        csum_add = 1'b1;
        if (cnt_reg == 5'd9) begin
          state_next = S_FOLD;
          cnt_next   = 5'd0;
        end
      end
      S_FOLD: begin
        csum_fold = 1'b1;
        if (cnt_reg == 5'd1) begin
          state_next = S_HEAD;
          cnt_next   = 5'd0;
        end
      end
      S_HEAD: begin
        if (cnt_reg == 5'd19) begin
          state_next = S_DONE;
          cnt_next   = 5'd0;
        end
      end
      S_DONE: begin
        id_cnt_next = id_cnt_reg + 16'd1;
        state_next  = S_IDLE;
        cnt_next    = 5'd0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  ip_csum16 u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (csum_clr),
    .add  (csum_add),
    .fold (csum_fold),
    .word (hdr_word),
    .csum (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      id_cnt_reg   <= '0;
      src_reg      <= '0;
      des_reg      <= '0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= '0;
      dat_reg      <= '0;
      head_end_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      id_cnt_reg   <= id_cnt_next;
      if (start) begin
        src_reg <= src_ip;
        des_reg <= des_ip;
      end
      wr_en_reg    <= (state_reg == S_HEAD);
      if (state_reg == S_HEAD) begin
        addr_reg <= RAM_BASE + ADDR_W'(cnt_reg);
        dat_reg  <= hdr_byte;
      end
      head_end_reg <= (state_reg == S_DONE);
      busy_reg     <= (state_reg != S_IDLE) || start;
    end
  end

  assign ip_wram_clk_en = wr_en_reg;
  assign ip_wram_addr   = addr_reg;
  assign ip_wram_dat    = dat_reg;
  assign ip_head_end    = head_end_reg;
  assign ip_busy        = busy_reg;

endmodule

// File: tb/tb_ip_head_pack.sv
// Directed bench for ip_head_pack: per-cycle strobe/done/busy timing and a
// byte-exact header image against a reference checksum model.
module tb_ip_head_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_ip, des_ip;
  logic        eth_head_end;
  logic        ip_head_end, ip_busy, ip_wram_clk_en;
  logic [9:0]  ip_wram_addr;
  logic [7:0]  ip_wram_dat;

  int checks   = 0;
  int failures = 0;
  logic [7:0] cap [20];

  always #5 clk = ~clk;

  ip_head_pack dut (
    .clk            (clk),
    .rst            (rst),
    .src_ip         (src_ip),
    .des_ip         (des_ip),
    .eth_head_end   (eth_head_end),
    .ip_head_end    (ip_head_end),
    .ip_busy        (ip_busy),
    .ip_wram_clk_en (ip_wram_clk_en),
    .ip_wram_addr   (ip_wram_addr),
    .ip_wram_dat    (ip_wram_dat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gold_byte(input int k, input logic [31:0] s,
                                           input logic [31:0] d, input logic [15:0] id);
    logic [15:0] w [10];
    logic [31:0] sum;
    w = '{16'h4500, 16'd989, id, 16'h4000, 16'h4011, 16'h0000,
          s[31:16], s[15:0], d[31:16], d[15:0]};
    sum = 32'd0;
    for (int i = 0; i < 10; i++) sum += {16'd0, w[i]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    w[5] = ~sum[15:0];
    return k[0] ? w[k/2][7:0] : w[k/2][15:8];
  endfunction

  // mode: 0 plain, 1 extra start pulses at T+5/T+34, 2 src change at T+5, 3 reset at T+20
  task automatic run_frame(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] id, input int mode);
    int strobes;
    int heads;
    logic [2:0] exp_v;
    strobes = 0;
    heads   = 0;
    src_ip = s;
    des_ip = d;
    eth_head_end = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      eth_head_end = 1'b0;
      if (mode == 3 && c >= 21) exp_v = 3'b000;
      else exp_v = {(c >= 14 && c <= 33), (c == 34), (c <= 34)};
      check($sformatf("ctl_id%h_c%0d", id, c),
            {29'd0, ip_wram_clk_en, ip_head_end, ip_busy}, {29'd0, exp_v});
      if (ip_wram_clk_en) strobes++;
      if (ip_head_end) heads++;
      if (exp_v[2]) begin
        cap[c-14] = ip_wram_dat;
        check($sformatf("addr_id%h_b%0d", id, c - 14), {22'd0, ip_wram_addr}, 22 + c - 14);
        check($sformatf("dat_id%h_b%0d", id, c - 14), {24'd0, ip_wram_dat},
              {24'd0, gold_byte(c - 14, s, d, id)});
      end
      if (mode == 1 && (c == 5 || c == 34)) eth_head_end = 1'b1;
      if (mode == 2 && c == 5) src_ip = ~s;
      if (mode == 3) rst = (c == 20);
    end
    rst = 1'b0;
    check($sformatf("strobes_id%h", id), strobes, (mode == 3) ? 7 : 20);
    check($sformatf("heads_id%h", id), heads, (mode == 3) ? 0 : 1);
    $display("frame id=%h mode=%0d src=%h des=%h strobes=%0d head_end=%0d",
             id, mode, s, d, strobes, heads);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    src_ip = '0;
    des_ip = '0;
    eth_head_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_en", {31'd0, ip_wram_clk_en}, 0);
    check("rst_addr", {22'd0, ip_wram_addr}, 0);
    check("rst_dat", {24'd0, ip_wram_dat}, 0);
    check("rst_head_end", {31'd0, ip_head_end}, 0);
    check("rst_busy", {31'd0, ip_busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(32'hC0A80102, 32'hC0A80101, 16'h0000, 0);
    check("csum_hi", {24'd0, cap[10]}, 32'hB3);
    check("csum_lo", {24'd0, cap[11]}, 32'hBC);

    run_frame(32'h0A000001, 32'h0A0000FE, 16'h0001, 0);
    run_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0002, 0);
    run_frame(32'h12345678, 32'h9ABCDEF0, 16'h0003, 1);
    run_frame(32'hAC100001, 32'hAC1000FF, 16'h0004, 2);

    force dut.id_cnt_reg = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.id_cnt_reg;
    run_frame(32'hC0A80102, 32'hC0A80101, 16'hFFFF, 0);
    run_frame(32'hC0A80102, 32'hC0A80101, 16'h0000, 0);

    run_frame(32'h01020304, 32'h05060708, 16'h0001, 3);
    repeat (2) @(negedge clk);
    run_frame(32'h01020304, 32'h05060708, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
